tdc_stream_sequencer: RTL and testbench
=======================================

TDC_STREAM_SEQUENCER -- requirements
Module: tdc_stream_sequencer

Interface
REQ-001 SHALL have parameter NP, default 10, the timestamp width in bits.
REQ-002 SHALL have parameter PIXEL_NUM, default 4, the number of pixels per acquisition.
REQ-003 SHALL have parameter ACQ_NUM, default 8, the number of acquisitions per frame.
REQ-004 SHALL have parameter GAP_CYCLES, default 2, the idle cycles after each acquisition burst (0 is legal).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port res, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: permits acceptance of a new acquisition.
REQ-008 SHALL have port acq_valid, input, 1 bit: acq_data holds one complete acquisition.
REQ-009 SHALL have port acq_data, input, PIXEL_NUM*NP bits: pixel p occupies bits [p*NP +: NP].
REQ-010 SHALL have port acq_ready, output, 1 bit: the block can accept an acquisition this cycle.
REQ-011 SHALL have port wrEn, output, 1 bit: data is a valid timestamp for the histogram builder.
REQ-012 SHALL have port data, output, NP bits: the serialized timestamp.
REQ-013 SHALL have port acq_idx, output, clog2(ACQ_NUM) bits: the index of the acquisition being sent.
REQ-014 SHALL have port frame_done, output, 1 bit: a one-cycle pulse after the last pixel of acquisition ACQ_NUM-1.

Function
REQ-015 SHALL use states IDLE, SEND and GAP, held in a registered state machine.
REQ-016 SHALL drive acq_ready combinationally as (state==IDLE) && en.
REQ-017 SHALL accept an acquisition only when acq_valid && acq_ready at a rising edge, capturing acq_data into an internal PIXEL_NUM*NP buffer on that edge.
REQ-018 SHALL transition IDLE->SEND on acceptance; with no acceptance it SHALL stay in IDLE.
REQ-019 SHALL, if acceptance occurs at edge k, assert wrEn in cycles k+1 through k+PIXEL_NUM, with data = pixel 0 through PIXEL_NUM-1 in ascending order, one pixel per cycle and no bubbles.
REQ-020 SHALL register wrEn, data, acq_idx and frame_done (no combinational path from inputs).
REQ-021 SHALL hold data at its last value while wrEn=0.
REQ-022 SHALL, after the last pixel, go SEND->GAP when GAP_CYCLES>0, or SEND->IDLE when GAP_CYCLES=0.
REQ-023 SHALL keep wrEn=0 for exactly GAP_CYCLES cycles in GAP, then return to IDLE.
REQ-024 SHALL use a pixel counter that runs 0..PIXEL_NUM-1 and a gap counter that runs 0..GAP_CYCLES-1, both clearing on state exit.
REQ-025 SHALL increment acq_idx after each completed burst, wrapping ACQ_NUM-1 -> 0.
REQ-026 SHALL assert frame_done for exactly one cycle, the cycle after the last wrEn of acquisition ACQ_NUM-1, and SHALL wrap acq_idx to 0 on that same edge.
REQ-027 SHALL let a burst already in SEND or GAP complete normally when en is deasserted mid-burst; en SHALL gate only new acceptance.
REQ-028 SHALL ignore acq_valid and changes to acq_data outside IDLE; the captured buffer SHALL NOT change during SEND or GAP.
REQ-029 SHALL leave acq_valid held high outside IDLE pending: it is accepted on the first IDLE cycle with en=1.

Reset
REQ-030 SHALL, when res=0 at a rising edge, set state=IDLE, wrEn=0, data=0, acq_idx=0, frame_done=0, all counters=0 and the buffer=0.
REQ-031 SHALL, on reset during SEND or GAP, abort the burst; wrEn SHALL be 0 from the cycle after that edge.
REQ-032 SHALL hold acq_ready at 0 while res=0.

Verification
REQ-033 SHALL pass basic burst: NP=10, PIXEL_NUM=4, GAP_CYCLES=2; accept {pixels 108,511,1022,200} -> wrEn=1 for 4 cycles with data 108,511,1022,200; then 2 cycles wrEn=0; acq_ready=1 again on the 7th cycle after acceptance.
REQ-034 SHALL pass back-to-back: acq_valid held high with en=1 over 3 acquisitions -> each burst is 4 wrEn cycles separated by exactly 2+1 non-wrEn cycles; acq_idx reads 0,1,2.
REQ-035 SHALL pass frame wrap: 8 acquisitions -> frame_done pulses once, 1 cycle after the 32nd wrEn; acq_idx=0 afterwards.
REQ-036 SHALL pass en drop mid-burst: deassert en at pixel 1 -> all 4 pixels still emitted; no further acceptance while en=0, despite acq_valid=1.
REQ-037 SHALL pass reset mid-burst: res=0 at pixel 2 -> wrEn=0 and data=0 the next cycle; state IDLE; acq_idx=0.
REQ-038 SHALL pass GAP_CYCLES=0: two back-to-back acquisitions -> exactly one wrEn=0 cycle between the bursts.

Source files
------------

// File: rtl/tdc_stream_sequencer.sv
// tdc_stream_sequencer: serializes one PIXEL_NUM-pixel TDC acquisition into a
// stream of NP-bit timestamps for a histogram builder, idles GAP_CYCLES after
// each burst, and pulses frame_done once every ACQ_NUM acquisitions.
//
// Ports:
//   clk         rising-edge clock
//   res         synchronous active-low reset
//   en          allows a new acquisition to be accepted
//   acq_valid   acq_data holds one complete acquisition
//   acq_data    pixel p occupies bits [p*NP +: NP]
//   acq_ready   an acquisition can be accepted this cycle
//   wrEn        data carries a valid timestamp
//   data        serialized timestamp, held while wrEn=0
//   acq_idx     index of the acquisition being sent
//   frame_done  one-cycle pulse after the last pixel of acquisition ACQ_NUM-1
module tdc_stream_sequencer #(
    parameter int NP         = 10,
    parameter int PIXEL_NUM  = 4,
    parameter int ACQ_NUM    = 8,
    parameter int GAP_CYCLES = 2,
    localparam int AW = ACQ_NUM > 1 ? $clog2(ACQ_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    en,
    input  logic                    acq_valid,
    input  logic [PIXEL_NUM*NP-1:0] acq_data,
    output logic                    acq_ready,
    output logic                    wrEn,
    output logic [NP-1:0]           data,
    output logic [AW-1:0]           acq_idx,
    output logic                    frame_done
);
    localparam int PW = PIXEL_NUM > 1 ? $clog2(PIXEL_NUM) : 1;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam int W  = PIXEL_NUM * NP;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [W-1:0]  cap_q, cap_d;
    logic          wr_en_q, wr_en_d;
    logic [NP-1:0] data_q, data_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          frame_done_q, frame_done_d;
    logic          last_pix, last_acq, last_gap;

    // res is included so the block never advertises readiness during reset
    assign acq_ready = (state_q == IDLE) && en && res;
    assign last_pix  = pix_q == PW'(PIXEL_NUM - 1);
    assign last_acq  = idx_q == AW'(ACQ_NUM - 1);
    assign last_gap  = gap_q == GW'(GAP_CYCLES - 1);

    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        gap_d        = gap_q;
        cap_d        = cap_q;
        wr_en_d      = 1'b0;
        data_d       = data_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: if (acq_valid && acq_ready) begin
                // pixel 0 goes out straight from the input so it appears the cycle after acceptance
                state_d = SEND;
                cap_d   = acq_data;
                pix_d   = '0;
                wr_en_d = 1'b1;
                data_d  = acq_data[NP-1:0];
            end
            SEND: if (last_pix) begin
                state_d      = GAP_CYCLES > 0 ? GAP : IDLE;
                pix_d        = '0;
                idx_d        = last_acq ? '0 : idx_q + 1'b1;
                frame_done_d = last_acq;
            end else begin
                pix_d   = pix_q + 1'b1;
                wr_en_d = 1'b1;
                data_d  = NP'(cap_q >> (NP * (int'(pix_q) + 1)));
            end
            GAP: begin
                state_d = last_gap ? IDLE : GAP;
                gap_d   = last_gap ? '0 : gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q      <= IDLE;
            pix_q        <= '0;
            gap_q        <= '0;
            cap_q        <= '0;
            wr_en_q      <= 1'b0;
            data_q       <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            gap_q        <= gap_d;
            cap_q        <= cap_d;
            wr_en_q      <= wr_en_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wrEn       = wr_en_q;
    assign data       = data_q;
    assign acq_idx    = idx_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_tdc_stream_sequencer.sv
// tb_tdc_stream_sequencer: checks two sequencers (GAP_CYCLES=2 and 0) against a burst-timeline model.
module tb_tdc_stream_sequencer;
    localparam int NP = 10, P = 4, ACQ = 8, W = NP * P, MAXC = 4096;

    logic clk = 1'b0, res = 1'b0, en = 1'b0, acq_valid = 1'b0;
    logic [W-1:0] acq_data = '0;
    logic rdy[2], wr[2], fd[2];
    logic [NP-1:0] dat[2];
    logic [2:0] idx[2];

    tdc_stream_sequencer #(.NP(NP), .PIXEL_NUM(P), .ACQ_NUM(ACQ), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .res(res), .en(en), .acq_valid(acq_valid), .acq_data(acq_data),
        .acq_ready(rdy[0]), .wrEn(wr[0]), .data(dat[0]), .acq_idx(idx[0]), .frame_done(fd[0]));
    tdc_stream_sequencer #(.NP(NP), .PIXEL_NUM(P), .ACQ_NUM(ACQ), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .res(res), .en(en), .acq_valid(acq_valid), .acq_data(acq_data),
        .acq_ready(rdy[1]), .wrEn(wr[1]), .data(dat[1]), .acq_idx(idx[1]), .frame_done(fd[1]));

    always #5 clk = ~clk;

    int total = 0, bad = 0, c = 0;
    bit armed = 1'b0;
    // model: one burst record per DUT, expressed as cycle numbers
    int bs[2] = '{-1, -1}, free_at[2] = '{0, 0}, e_idx[2] = '{0, 0}, bidx[2] = '{0, 0};
    logic [NP-1:0] e_data[2] = '{'0, '0};
    logic [NP-1:0] pix[2][P];
    bit h_wr[2][MAXC], h_fd[2][MAXC], h_rdy[2][MAXC];
    logic [NP-1:0] h_dat[2][MAXC];
    int h_idx[2][MAXC];

    function automatic int gapc(input int u);
        return u == 0 ? 2 : 0;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] x;
        for (int p = 0; p < P; p++) x[p*NP +: NP] = NP'($urandom);
        return x;
    endfunction

    task automatic step(input bit r, input bit e, input bit v, input logic [W-1:0] d);
        bit acc[2];
        bit er, ew, efd;
        res = r; en = e; acq_valid = v; acq_data = d;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            er = r && e && c >= free_at[u];
            ew = bs[u] >= 0 && c > bs[u] && c <= bs[u] + P;
            if (ew) e_data[u] = pix[u][c - bs[u] - 1];
            efd = bs[u] >= 0 && c == bs[u] + P + 1 && bidx[u] == ACQ - 1;
            if (bs[u] >= 0 && c == bs[u] + P + 1) e_idx[u] = (e_idx[u] + 1) % ACQ;
            total++;
            if (rdy[u] !== er) begin bad++; $display("FAIL ready dut%0d cyc=%0d got=%b exp=%b", u, c, rdy[u], er); end
            if (armed) begin
                total++;
                if (wr[u] !== ew) begin bad++; $display("FAIL wrEn dut%0d cyc=%0d got=%b exp=%b", u, c, wr[u], ew); end
                total++;
                if (dat[u] !== e_data[u]) begin bad++; $display("FAIL data dut%0d cyc=%0d got=%0d exp=%0d", u, c, dat[u], e_data[u]); end
                total++;
                if (idx[u] !== 3'(e_idx[u])) begin bad++; $display("FAIL acq_idx dut%0d cyc=%0d got=%0d exp=%0d", u, c, idx[u], e_idx[u]); end
                total++;
                if (fd[u] !== efd) begin bad++; $display("FAIL frame_done dut%0d cyc=%0d got=%b exp=%b", u, c, fd[u], efd); end
            end
            if (c < MAXC) begin
                h_wr[u][c] = wr[u]; h_fd[u][c] = fd[u]; h_rdy[u][c] = rdy[u];
                h_dat[u][c] = dat[u]; h_idx[u][c] = int'(idx[u]);
            end
            acc[u] = er && v;
        end
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            if (!r) begin
                bs[u] = -1; free_at[u] = c + 1; e_idx[u] = 0; e_data[u] = '0;
            end else if (acc[u]) begin
                bs[u] = c; bidx[u] = e_idx[u]; free_at[u] = c + P + gapc(u) + 1;
                for (int p = 0; p < P; p++) pix[u][p] = d[p*NP +: NP];
            end
        end
        if (!r) armed = 1'b1;
        c++;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, rnd());
        for (int u = 0; u < 2; u++) begin
            total++;
            if (wr[u] !== 1'b0 || dat[u] !== '0 || idx[u] !== 3'd0 || fd[u] !== 1'b0 || rdy[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state dut%0d wr=%b data=%0d idx=%0d fd=%b rdy=%b exp all 0", u, wr[u], dat[u], idx[u], fd[u], rdy[u]);
            end
        end
    endtask

    task automatic test_basic_burst();
        int s;
        int want[P] = '{108, 511, 1022, 200};
        logic [W-1:0] d;
        d = {10'd200, 10'd1022, 10'd511, 10'd108};
        step(1'b1, 1'b1, 1'b0, rnd());
        s = c;
        step(1'b1, 1'b1, 1'b1, d);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, rnd());
        for (int i = 1; i <= P; i++) begin
            total++;
            if (h_wr[0][s+i] !== 1'b1 || h_dat[0][s+i] !== NP'(want[i-1]))
                begin bad++; $display("FAIL basic_pixel%0d got wr=%b data=%0d exp wr=1 data=%0d", i - 1, h_wr[0][s+i], h_dat[0][s+i], want[i-1]); end
        end
        for (int i = 5; i <= 6; i++) begin
            total++;
            if (h_wr[0][s+i] !== 1'b0 || h_rdy[0][s+i] !== 1'b0)
                begin bad++; $display("FAIL basic_gap cyc+%0d got wr=%b rdy=%b exp 0 0", i, h_wr[0][s+i], h_rdy[0][s+i]); end
        end
        total++;
        if (h_rdy[0][s+7] !== 1'b1) begin bad++; $display("FAIL basic_ready7 got=%b exp=1", h_rdy[0][s+7]); end
    endtask

    task automatic test_back_to_back();
        int s, run, zeros, nb;
        step(1'b0, 1'b1, 1'b0, rnd());
        s = c;
        for (int i = 0; i < 21; i++) step(1'b1, 1'b1, 1'b1, rnd());
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, rnd());
        for (int u = 0; u < 2; u++) begin
            run = 0; zeros = 0; nb = 0;
            for (int t = s; t < c; t++) begin
                if (h_wr[u][t]) begin
                    if (run == 0) begin
                        total++;
                        if (h_idx[u][t] != nb % ACQ) begin bad++; $display("FAIL b2b_idx dut%0d burst%0d got=%0d exp=%0d", u, nb, h_idx[u][t], nb % ACQ); end
                        if (nb > 0) begin
                            total++;
                            if (zeros != gapc(u) + 1) begin bad++; $display("FAIL b2b_gap dut%0d burst%0d got=%0d exp=%0d", u, nb, zeros, gapc(u) + 1); end
                        end
                        nb++;
                    end
                    run++; zeros = 0;
                end else begin
                    if (run > 0) begin
                        total++;
                        if (run != P) begin bad++; $display("FAIL b2b_len dut%0d got=%0d exp=%0d", u, run, P); end
                    end
                    run = 0; zeros++;
                end
            end
            total++;
            if (nb != (u == 0 ? 3 : 5)) begin bad++; $display("FAIL b2b_count dut%0d got=%0d exp=%0d", u, nb, u == 0 ? 3 : 5); end
        end
    endtask

    task automatic test_frame_wrap();
        int s, nw, t32, nfd, tfd;
        step(1'b0, 1'b1, 1'b0, rnd());
        s = c;
        for (int i = 0; i < 56; i++) step(1'b1, 1'b1, 1'b1, rnd());
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, rnd());
        for (int u = 0; u < 2; u++) begin
            nw = 0; t32 = -1; nfd = 0; tfd = -1;
            for (int t = s; t < c; t++) begin
                if (h_wr[u][t]) begin nw++; if (nw == 32) t32 = t; end
                if (h_fd[u][t]) begin nfd++; tfd = t; end
            end
            total++;
            if (nfd != 1 || tfd != t32 + 1)
                begin bad++; $display("FAIL frame_done dut%0d got pulses=%0d at=%0d exp pulses=1 at=%0d", u, nfd, tfd, t32 + 1); end
        end
        total++;
        if (idx[0] !== 3'd0) begin bad++; $display("FAIL frame_idx_wrap got=%0d exp=0", idx[0]); end
        total++;
        if (idx[1] !== 3'd4) begin bad++; $display("FAIL frame_idx_dut1 got=%0d exp=4", idx[1]); end
    endtask

    task automatic test_en_drop();
        int s;
        logic [W-1:0] d;
        step(1'b0, 1'b1, 1'b0, rnd());
        d = rnd();
        s = c;
        step(1'b1, 1'b1, 1'b1, d);
        step(1'b1, 1'b1, 1'b1, rnd());
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b1, rnd());
        step(1'b1, 1'b1, 1'b1, rnd());
        step(1'b1, 1'b1, 1'b0, rnd());
        for (int u = 0; u < 2; u++) begin
            for (int i = 1; i <= P; i++) begin
                total++;
                if (h_wr[u][s+i] !== 1'b1 || h_dat[u][s+i] !== d[(i-1)*NP +: NP])
                    begin bad++; $display("FAIL endrop_pixel dut%0d p%0d got wr=%b data=%0d exp wr=1 data=%0d", u, i - 1, h_wr[u][s+i], h_dat[u][s+i], d[(i-1)*NP +: NP]); end
            end
            for (int t = s + 5; t <= s + 16; t++) begin
                total++;
                if (h_wr[u][t] !== 1'b0 || h_rdy[u][t] !== 1'b0)
                    begin bad++; $display("FAIL endrop_hold dut%0d cyc=%0d got wr=%b rdy=%b exp 0 0", u, t, h_wr[u][t], h_rdy[u][t]); end
            end
            total++;
            if (h_wr[u][s+18] !== 1'b1) begin bad++; $display("FAIL endrop_resume dut%0d got=%b exp=1", u, h_wr[u][s+18]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int s;
        logic [W-1:0] d;
        step(1'b0, 1'b1, 1'b0, rnd());
        step(1'b1, 1'b1, 1'b1, rnd());
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, rnd());
        d = rnd();
        s = c;
        step(1'b1, 1'b1, 1'b1, d);
        step(1'b1, 1'b1, 1'b0, rnd());
        step(1'b1, 1'b1, 1'b0, rnd());
        step(1'b0, 1'b1, 1'b0, rnd());
        step(1'b1, 1'b1, 1'b0, rnd());
        for (int u = 0; u < 2; u++) begin
            total++;
            if (h_wr[u][s+3] !== 1'b1 || h_dat[u][s+3] !== d[2*NP +: NP] || h_idx[u][s+3] != 1)
                begin bad++; $display("FAIL rstmid_pre dut%0d got wr=%b data=%0d idx=%0d exp 1 %0d 1", u, h_wr[u][s+3], h_dat[u][s+3], h_idx[u][s+3], d[2*NP +: NP]); end
            total++;
            if (h_wr[u][s+4] !== 1'b0 || h_dat[u][s+4] !== '0 || h_idx[u][s+4] != 0 || h_rdy[u][s+4] !== 1'b1)
                begin bad++; $display("FAIL rstmid_post dut%0d got wr=%b data=%0d idx=%0d rdy=%b exp 0 0 0 1", u, h_wr[u][s+4], h_dat[u][s+4], h_idx[u][s+4], h_rdy[u][s+4]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 1'($urandom), rnd());
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_back_to_back();
        test_frame_wrap();
        test_en_drop();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
